// File: rtl/brick_pkg.sv
// brick_pkg
//   Shared types and helpers for the bit-brick accumulation controller.
//   - prec_e        : operand precision code (2b / 4b / 8b, code 3 aliases 8b)
//   - state_e       : controller FSM states
//   - BRICK_SUM_W   : width of the signed 16-lane adder output
//   - BRICK_BITS    : bits per brick (each brick index step is a 2-bit shift)
//   - brick_count   : precision code -> number of 2-bit bricks (1, 2 or 4)
//   - brick_last_sel: precision code -> index of the MSB (signed) brick
package brick_pkg;

  typedef enum logic [1:0] {
    PREC_2B     = 2'd0,
    PREC_4B     = 2'd1,
    PREC_8B     = 2'd2,
    PREC_8B_ALT = 2'd3
  } prec_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int BRICK_SUM_W = 9;
  localparam int BRICK_BITS  = 2;

  // Code 3 is not a real precision; treat it as 8b so a bad config still
  // produces a well-formed (full precision) job.
  function automatic logic [2:0] brick_count(input prec_e prec);
    case (prec)
      PREC_2B: brick_count = 3'd1;
      PREC_4B: brick_count = 3'd2;
      default: brick_count = 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] brick_last_sel(input prec_e prec);
    logic [2:0] cnt;
    cnt = brick_count(prec);
    brick_last_sel = 2'(cnt - 3'd1);
  endfunction

endpackage

// File: rtl/brick_loop_cnt.sv
// brick_loop_cnt
//   Nested issue counters for one job: vector chunk (outer), weight brick,
//   activation brick (inner). Counters clear on i_clear and advance once per
//   i_adv. On the last issue they hold, so the final selects stay visible
//   after the run ends.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_clear          zero all counters (job start)
//   i_adv            one issue happened this cycle, step to the next pair
//   i_nw_m1/i_na_m1  last weight / activation brick index for this job
//   i_nvec_m1        last vector chunk index for this job
//   o_vec_idx        current chunk index
//   o_w_sel/o_a_sel  current weight / activation brick index
//   o_last           current position is the final issue of the job
module brick_loop_cnt #(
  parameter int VEC_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_adv,
  input  logic [1:0]       i_nw_m1,
  input  logic [1:0]       i_na_m1,
  input  logic [VEC_W-1:0] i_nvec_m1,
  output logic [VEC_W-1:0] o_vec_idx,
  output logic [1:0]       o_w_sel,
  output logic [1:0]       o_a_sel,
  output logic             o_last
);

  logic [VEC_W-1:0] vec_q, vec_d;
  logic [1:0]       w_q, w_d;
  logic [1:0]       a_q, a_d;

  logic a_wrap, w_wrap, v_last;

  assign a_wrap = (a_q == i_na_m1);
  assign w_wrap = (w_q == i_nw_m1);
  assign v_last = (vec_q == i_nvec_m1);
  assign o_last = a_wrap && w_wrap && v_last;

  always_comb begin
    vec_d = vec_q;
    w_d   = w_q;
    a_d   = a_q;
    if (i_clear) begin
      vec_d = '0;
      w_d   = '0;
      a_d   = '0;
    end else if (i_adv && !o_last) begin
      if (!a_wrap) begin
        a_d = a_q + 2'd1;
      end else begin
        a_d = '0;
        if (!w_wrap) begin
          w_d = w_q + 2'd1;
        end else begin
          w_d   = '0;
          vec_d = vec_q + VEC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vec_q <= '0;
      w_q   <= '0;
      a_q   <= '0;
    end else begin
      vec_q <= vec_d;
      w_q   <= w_d;
      a_q   <= a_d;
    end
  end

  assign o_vec_idx = vec_q;
  assign o_w_sel   = w_q;
  assign o_a_sel   = a_q;

endmodule

// File: rtl/brick_accum_ctrl.sv
// brick_accum_ctrl
//   Sequencer for the 16-lane brick adder. A job walks every (chunk, weight
//   brick, activation brick) triple, one per cycle, and accumulates each adder
//   sum shifted by its brick significance into a signed result that is
//   returned over a valid/ready handshake.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start                   job start, only taken in IDLE
//   i_w_prec, i_a_prec        precision codes (0=2b, 1=4b, 2/3=8b)
//   i_num_vec                 number of 16-element chunks (0 means 1)
//   o_busy                    job in progress (RUN, DRAIN, DONE)
//   o_issue                   selects below are valid this cycle
//   o_vec_idx, o_w_sel, o_a_sel  current chunk and brick indices
//   o_w_signed, o_a_signed    current brick is the operand's MSB brick
//   i_brick_sum               adder output for the previous cycle's selects
//   o_result, o_valid, i_ready  result handshake
module brick_accum_ctrl
  import brick_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int VEC_W = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [1:0]                    i_w_prec,
  input  logic [1:0]                    i_a_prec,
  input  logic [VEC_W-1:0]              i_num_vec,
  output logic                          o_busy,
  output logic                          o_issue,
  output logic [VEC_W-1:0]              o_vec_idx,
  output logic [1:0]                    o_w_sel,
  output logic [1:0]                    o_a_sel,
  output logic                          o_w_signed,
  output logic                          o_a_signed,
  input  logic signed [BRICK_SUM_W-1:0] i_brick_sum,
  output logic signed [ACC_W-1:0]       o_result,
  output logic                          o_valid,
  input  logic                          i_ready
);

  state_e state_q, state_d;

  // Job configuration latched at start so the inputs may change mid-job.
  logic [1:0]       nw_m1_q, nw_m1_d;
  logic [1:0]       na_m1_q, na_m1_d;
  logic [VEC_W-1:0] nvec_m1_q, nvec_m1_d;

  // Copy of the issue and selects from the previous cycle, aligned with the
  // adder output that arrives one cycle after the selects.
  logic       issue_d1_q;
  logic [1:0] w_sel_d1_q;
  logic [1:0] a_sel_d1_q;

  logic [ACC_W-1:0] acc_q, acc_d;

  logic             start_take;
  logic             last_issue;
  logic [ACC_W-1:0] sum_ext;
  logic [3:0]       shamt;
  logic [ACC_W-1:0] addend;

  assign start_take = (state_q == ST_IDLE) && i_start;

  // Configuration next-state: load only on an accepted start.
  always_comb begin
    nw_m1_d   = nw_m1_q;
    na_m1_d   = na_m1_q;
    nvec_m1_d = nvec_m1_q;
    if (start_take) begin
      nw_m1_d   = brick_last_sel(prec_e'(i_w_prec));
      na_m1_d   = brick_last_sel(prec_e'(i_a_prec));
      nvec_m1_d = (i_num_vec == '0) ? '0 : (i_num_vec - VEC_W'(1));
    end
  end

  brick_loop_cnt #(
    .VEC_W (VEC_W)
  ) u_loop_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (start_take),
    .i_adv     (o_issue),
    .i_nw_m1   (nw_m1_q),
    .i_na_m1   (na_m1_q),
    .i_nvec_m1 (nvec_m1_q),
    .o_vec_idx (o_vec_idx),
    .o_w_sel   (o_w_sel),
    .o_a_sel   (o_a_sel),
    .o_last    (last_issue)
  );

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_issue = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        o_busy  = 1'b1;
        o_issue = 1'b1;
        if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The last issue's sum lands this cycle; nothing new is issued.
        o_busy  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Brick significance: weight brick w and activation brick a together
  // contribute at bit position 2*(w + a).
  assign sum_ext = {{(ACC_W-BRICK_SUM_W){i_brick_sum[BRICK_SUM_W-1]}}, i_brick_sum};
  assign shamt   = {1'b0, w_sel_d1_q, 1'b0} + {1'b0, a_sel_d1_q, 1'b0};
  assign addend  = sum_ext << shamt;

  // Accumulator wraps at ACC_W by plain modular addition.
  always_comb begin
    acc_d = acc_q;
    if (start_take) begin
      acc_d = '0;
    end else if (issue_d1_q) begin
      acc_d = acc_q + addend;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      nw_m1_q    <= '0;
      na_m1_q    <= '0;
      nvec_m1_q  <= '0;
      issue_d1_q <= 1'b0;
      w_sel_d1_q <= '0;
      a_sel_d1_q <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      nw_m1_q    <= nw_m1_d;
      na_m1_q    <= na_m1_d;
      nvec_m1_q  <= nvec_m1_d;
      issue_d1_q <= o_issue;
      w_sel_d1_q <= o_w_sel;
      a_sel_d1_q <= o_a_sel;
      acc_q      <= acc_d;
    end
  end

  // Signedness flags qualify the issued selects; outside RUN they are low.
  assign o_w_signed = o_issue && (o_w_sel == nw_m1_q);
  assign o_a_signed = o_issue && (o_a_sel == na_m1_q);
  assign o_result   = acc_q;

endmodule
